// File: rtl/adder_pipe.sv
// Elastic pipelined adder/subtractor with wrap, unsigned-saturate and
// signed-saturate modes, carry/overflow/saturation flags and full backpressure.
module adder_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf,
    output logic             sat
);
    localparam int M = WIDTH - 1;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             ovf;
        logic             sat;
    } res_t;

    logic             sub;
    logic [WIDTH:0]   raw;
    res_t             res_d;
    res_t [DEPTH:1]   st;
    logic [DEPTH:1]   vld;
    logic [DEPTH:1]   rdy;
    logic             rdy_acc;

    // The WIDTH+1 bit of the subtraction is exactly the unsigned borrow.
    always_comb begin
        sub         = (mode == 2'b11);
        raw         = sub ? ({1'b0, in1} - {1'b0, in2}) : ({1'b0, in1} + {1'b0, in2});
        res_d.carry = raw[WIDTH];
        res_d.ovf   = (sub ? (in1[M] != in2[M]) : (in1[M] == in2[M])) && (raw[M] != in1[M]);
        res_d.sum   = raw[M:0];
        res_d.sat   = 1'b0;
        case (mode)
            2'b01: if (res_d.carry) begin
                res_d.sum = '1;
                res_d.sat = 1'b1;
            end
            2'b10: if (res_d.ovf) begin
                res_d.sum = {in1[M], {M{~in1[M]}}};
                res_d.sat = 1'b1;
            end
            default: ;
        endcase
    end

    // A stage can load if it or any stage downstream of it is empty.
    always_comb begin
        rdy     = '0;
        rdy_acc = out_ready;
        for (int k = DEPTH; k >= 1; k--) begin
            rdy_acc = !vld[k] || rdy_acc;
            rdy[k]  = rdy_acc;
        end
    end

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        logic up_vld;
        res_t up_res;
        logic vld_q;
        res_t res_q;

        if (k == 1) begin : g_first
            assign up_vld = in_valid;
            assign up_res = res_d;
        end else begin : g_fwd
            assign up_vld = vld[k-1];
            assign up_res = st[k-1];
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                vld_q <= 1'b0;
                res_q <= '0;
            end else if (rdy[k]) begin
                vld_q <= up_vld;
                if (up_vld) res_q <= up_res;
            end
        end

        assign vld[k] = vld_q;
        assign st[k]  = res_q;
    end

    assign in_ready  = rdy[1];
    assign out_valid = vld[DEPTH];
    assign sum       = st[DEPTH].sum;
    assign carry     = st[DEPTH].carry;
    assign ovf       = st[DEPTH].ovf;
    assign sat       = st[DEPTH].sat;
endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: directed arithmetic vectors, backpressure, reset and a
// randomized handshake run against an arithmetic reference model.
module tb_adder_pipe;
    localparam int W = 8;
    localparam int D = 2;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic [1:0]   mode = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         carry, ovf, sat;

    int tests = 0;
    int fails = 0;

    adder_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry), .ovf(ovf), .sat(sat)
    );

    always #5 clock = ~clock;

    // {sum, carry, ovf, sat} from integer arithmetic on the operand values
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] m);
        int ua, ub, sa, sb, r, sr;
        logic c, o, s;
        logic [W-1:0] y;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        if (m == 2'b11) begin
            r = ua - ub; sr = sa - sb; c = (ua < ub);
        end else begin
            r = ua + ub; sr = sa + sb; c = (r > 255);
        end
        o = (sr > 127) || (sr < -128);
        y = W'(r & 255);
        s = 1'b0;
        if (m == 2'b01 && c) begin y = 8'hFF; s = 1'b1; end
        if (m == 2'b10 && o) begin y = (sr > 0) ? 8'h7F : 8'h80; s = 1'b1; end
        return {y, c, o, s};
    endfunction

    task automatic test_reset;
        @(negedge clock);
        reset = 1'b0;
        #1;
        tests++;
        if ({out_valid, sum, carry, ovf, sat} !== '0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: out_valid=%b sum=%h c=%b o=%b s=%b in_ready=%b, want all 0 and in_ready=1",
                     out_valid, sum, carry, ovf, sat, in_ready);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_directed;
        // a, b, mode, expected {sum, carry, ovf, sat}
        logic [W-1:0] va [7] = '{8'hFF, 8'd200, 8'd20, 8'd100, 8'h9C, 8'd5, 8'h80};
        logic [W-1:0] vb [7] = '{8'h01, 8'd100, 8'd30, 8'd50, 8'hCE, 8'd7, 8'h01};
        logic [1:0]   vm [7] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
        logic [W+2:0] ve [7] = '{{8'h00, 3'b100}, {8'hFF, 3'b101}, {8'd50, 3'b000},
                                 {8'h7F, 3'b011}, {8'h80, 3'b111}, {8'hFE, 3'b100},
                                 {8'h7F, 3'b010}};
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            in_valid = 1'b1; in1 = va[i]; in2 = vb[i]; mode = vm[i]; out_ready = 1'b1;
            #1;
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready);
            end
            @(negedge clock);
            in_valid = 1'b0; in1 = $urandom_range(0, 255); in2 = $urandom_range(0, 255);
            #1;
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL dir%0d_early: out_valid=%b want 0 one edge after accept", i, out_valid);
            end
            @(negedge clock);
            #1;
            tests++;
            if (out_valid !== 1'b1 || {sum, carry, ovf, sat} !== ve[i]) begin
                fails++;
                $display("FAIL dir%0d_result: valid=%b {sum,c,o,s}=%h want valid=1 %h",
                         i, out_valid, {sum, carry, ovf, sat}, ve[i]);
            end
            tests++;
            if (ve[i] !== model(va[i], vb[i], vm[i])) begin
                fails++;
                $display("FAIL dir%0d_model: model=%h table=%h", i, model(va[i], vb[i], vm[i]), ve[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        int sent = 0, got = 0;
        logic pstall = 1'b0;
        logic [W-1:0] psum = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            in_valid = (sent < 6); in1 = W'(sent); in2 = 8'd1; mode = 2'b00;
            out_ready = (c >= 4);
            #1;
            if (c == 2 || c == 3) begin
                tests++;
                if (in_ready !== 1'b0 || sent != 2) begin
                    fails++;
                    $display("FAIL bp_full_c%0d: in_ready=%b accepted=%0d want 0 and 2", c, in_ready, sent);
                end
            end
            if (pstall) begin
                tests++;
                if (out_valid !== 1'b1 || sum !== psum) begin
                    fails++;
                    $display("FAIL bp_stable: valid=%b sum=%h want 1 and %h", out_valid, sum, psum);
                end
            end
            pstall = out_valid && !out_ready;
            psum = sum;
            if (out_valid && out_ready) begin
                tests++;
                if (sum !== W'(got + 1)) begin
                    fails++;
                    $display("FAIL bp_order: got %0d want %0d", sum, got + 1);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        tests++;
        if (got != 6 || sent != 6) begin
            fails++;
            $display("FAIL bp_count: out=%0d in=%0d want 6 and 6", got, sent);
        end
    endtask

    task automatic test_reset_midflight;
        @(negedge clock);
        out_ready = 1'b0; in_valid = 1'b1; in1 = 8'd10; in2 = 8'd20; mode = 2'b00;
        @(negedge clock);
        in1 = 8'd30;
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_fill: out_valid=%b in_ready=%b want 1 and 0", out_valid, in_ready);
        end
        reset = 1'b0;
        #1;
        tests++;
        if ({out_valid, sum, carry, ovf, sat} !== '0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_flush: valid=%b sum=%h c=%b o=%b s=%b in_ready=%b want zeros, in_ready=1",
                     out_valid, sum, carry, ovf, sat, in_ready);
        end
        @(negedge clock);
        reset = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in1 = 8'd3; in2 = 8'd4;
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_latency: out_valid=%b want 0 one edge after accept", out_valid);
        end
        @(negedge clock);
        #1;
        tests++;
        if (out_valid !== 1'b1 || sum !== 8'd7) begin
            fails++;
            $display("FAIL rst_result: valid=%b sum=%0d want 1 and 7", out_valid, sum);
        end
    endtask

    task automatic test_random;
        logic [W+2:0] q[$];
        logic [W+2:0] exp, obs, pobs;
        logic pstall = 1'b0;
        pobs = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            in_valid  = (c < 2900) && ($urandom_range(0, 3) != 0);
            in1       = W'($urandom_range(0, 255));
            in2       = W'($urandom_range(0, 255));
            mode      = 2'($urandom_range(0, 3));
            out_ready = (c >= 2900) || ($urandom_range(0, 2) != 0);
            #1;
            obs = {sum, carry, ovf, sat};
            tests++;
            if (in_ready !== (out_ready || q.size() < D)) begin
                fails++;
                $display("FAIL rnd_in_ready c%0d: got %b occupancy=%0d out_ready=%b",
                         c, in_ready, q.size(), out_ready);
            end
            if (pstall) begin
                tests++;
                if (out_valid !== 1'b1 || obs !== pobs) begin
                    fails++;
                    $display("FAIL rnd_hold c%0d: valid=%b got %h want %h", c, out_valid, obs, pobs);
                end
            end
            pstall = out_valid && !out_ready;
            pobs = obs;
            if (out_valid && out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL rnd_spurious c%0d: got %h with nothing pending", c, obs);
                end else begin
                    exp = q.pop_front();
                    if (obs !== exp) begin
                        fails++;
                        $display("FAIL rnd_data c%0d: got %h want %h", c, obs, exp);
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(model(in1, in2, mode));
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL rnd_drain: %0d beats never emerged", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, elastic-pipelined adder/subtractor: successor to the single-stage adder DUT. Adds configurable operand width, pipeline depth, four arithmetic modes (wrap add, unsigned-saturate add, signed-saturate add, wrap subtract), carry/overflow/saturation flags and a valid/ready handshake with full backpressure. It sits between the stimulus driver interface and the scoreboard/monitor path of the adder testbench, and is reused as the arithmetic datapath block in the design.

## Interface
- WIDTH, 8: operand and result width in bits, ≥2.
- DEPTH, 2: pipeline stages from input acceptance to output, ≥1.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- in1  in  WIDTH  operand A.
- in2  in  WIDTH  operand B.
- mode  in  2  00 wrap add, 01 unsigned-saturate add, 10 signed-saturate add, 11 wrap subtract (in1 − in2).
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- carry  out  1  unsigned carry-out (add) or borrow (subtract).
- ovf  out  1  two's-complement overflow of the unsaturated result.
- sat  out  1  result was clamped (modes 01/10 only).

## Operation
- Compute at acceptance: raw = in1 ± in2 at WIDTH+1 bits; all flags derive from raw and operand MSBs.
- carry: add → raw[WIDTH]; subtract → 1 iff in1 < in2 unsigned.
- ovf: add → operand MSBs equal and raw[WIDTH-1] differs; subtract → operand MSBs differ and raw[WIDTH-1] ≠ in1 MSB. ovf is reported in every mode.
- Mode 00/11: sum = raw[WIDTH-1:0], sat = 0.
- Mode 01: if carry, sum = all-ones, sat = 1; else wrap result.
- Mode 10: if ovf, sum = 0x7F..F when both operands non-negative, 0x80..0 when both negative; sat = 1; else wrap result.
- Pipeline: DEPTH registered stages, each holding {valid, sum, carry, ovf, sat}. Computation is registered into stage 1; stages 2..DEPTH forward unchanged.
- Stage k ready: rdy_k = !valid_k | rdy_{k+1}; rdy_{DEPTH+1} = out_ready. in_ready = rdy_1 (combinational from out_ready; no bubbles required).
- A stage loads when its rdy is high: captures upstream beat if upstream valid, else clears valid. A stage with rdy low holds all fields.
- Transfer on input when in_valid & in_ready; on output when out_valid & out_ready. No beat is dropped or duplicated; order preserved.
- sum/flags held stable while out_valid & !out_ready.

## Timing
- Reset (reset=0, async): all stage valids 0, all data fields 0; out_valid=0, sum=0, carry=0, ovf=0, sat=0. in_ready=1 while out_ready=1 or the pipe is empty (always after reset).
- Reset mid-operation: in-flight beats discarded immediately; first accepted beat after reset release emerges DEPTH cycles later.
- Latency: beat accepted at edge N appears with out_valid=1 after edge N+DEPTH-1 (visible in cycle following edge N+DEPTH-1), given no stall.
- Throughput: one beat/cycle with out_ready held high.
- Full pipe (all DEPTH valids set) with out_ready=0: in_ready=0, nothing advances.
- Full pipe, out_ready=1: simultaneous output and input transfer in same cycle; occupancy unchanged.
- Bubbles collapse: a stalled output with empty upstream stages still accepts up to DEPTH-1 further beats.
- in1/in2/mode sampled only on acceptance edge; changes while in_ready=0 have no effect.

## Test plan
- WIDTH=8, DEPTH=2, mode 00: in1=0xFF, in2=0x01 → sum=0x00, carry=1, ovf=0, sat=0, out_valid 2 cycles after acceptance.
- Mode 01: 200+100 → sum=0xFF, carry=1, sat=1; 20+30 → sum=50, sat=0.
- Mode 10: 100+50 → sum=0x7F, ovf=1, sat=1; (−100)+(−50) (0x9C+0xCE) → sum=0x80, ovf=1, sat=1.
- Mode 11: 5−7 → sum=0xFE, carry=1, ovf=0; 0x80−0x01 → sum=0x7F, ovf=1, sat=0.
- Backpressure: stream 6 beats (0+1..5+1) with out_ready=0 for 4 cycles then 1 → in_ready drops after 2 beats accepted, outputs 1..6 in order, none lost/duplicated, sum stable while stalled.
- Reset: assert reset=0 with 2 beats in flight → out_valid and all outputs 0 immediately; after release, new beat 3+4 emerges as 7 after 2-cycle latency.
